// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU sequencer: states, opcodes, ALU codes
// and the opcode classification bundle.
package cpu_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned ALU_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OP_W-1:0] OP_JMP = 4'b0001;
    localparam logic [OP_W-1:0] OP_LDW = 4'b0010;
    localparam logic [OP_W-1:0] OP_STW = 4'b0011;
    localparam logic [OP_W-1:0] OP_RTR = 4'b0100;
    localparam logic [OP_W-1:0] OP_BLT = 4'b0101;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0110;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0111;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [ALU_W-1:0] ALU_ADD    = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB    = 2'b01;
    localparam logic [ALU_W-1:0] ALU_PASS_A = 2'b10;

    // One-hot opcode class; exactly one field is set for any opcode.
    typedef struct packed {
        logic jump;
        logic branch;
        logic load;
        logic store;
        logic alu;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier shared by decode and execute stages.
module op_classify
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output op_class_t       op_class_c
);

    always_comb begin
        op_class_c = '0;
        case (opcode)
            OP_JMP:                 op_class_c.jump    = 1'b1;
            OP_BLT:                 op_class_c.branch  = 1'b1;
            OP_LDW:                 op_class_c.load    = 1'b1;
            OP_STW:                 op_class_c.store   = 1'b1;
            OP_ADD, OP_SUB, OP_RTR: op_class_c.alu     = 1'b1;
            OP_HLT:                 op_class_c.halt    = 1'b1;
            default:                op_class_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/memory/writeback
// FSM with control outputs decoded from state, latched opcode and inputs.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic [OP_W-1:0]    opcode,
    input  logic               LT_flag,
    input  logic               mem_ack,
    output logic [STATE_W-1:0] state,
    output logic               PC_EN,
    output logic               PC_in_op,
    output logic               IR_EN,
    output logic               read_1EN,
    output logic               read_2EN,
    output logic               reg_file_wrEN,
    output logic               write_reg_from_memory,
    output logic [ALU_W-1:0]   alu_control,
    output logic               EN_mem_add,
    output logic               mem_req,
    output logic               RAM_wrEN,
    output logic               halted,
    output logic               illegal_op
);

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] opcode_q;
    logic [OP_W-1:0] cls_opcode;
    op_class_t       op_class;

    // Decode looks at the live opcode; later states use the latched copy.
    assign cls_opcode = (state_q == S_DECODE) ? opcode : opcode_q;

    op_classify u_op_classify (
        .opcode     (cls_opcode),
        .op_class_c (op_class)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    // Next state and control decode; everything is forced low while reset_n
    // is asserted so no write strobe is visible in the reset cycle.
    always_comb begin
        state_d               = state_q;
        state                 = '0;
        PC_EN                 = 1'b0;
        PC_in_op              = 1'b0;
        IR_EN                 = 1'b0;
        read_1EN              = 1'b0;
        read_2EN              = 1'b0;
        reg_file_wrEN         = 1'b0;
        write_reg_from_memory = 1'b0;
        alu_control           = ALU_ADD;
        EN_mem_add            = 1'b0;
        mem_req               = 1'b0;
        RAM_wrEN              = 1'b0;
        halted                = 1'b0;
        illegal_op            = 1'b0;

        if (reset_n) begin
            state = STATE_W'(state_q);
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        IR_EN   = 1'b1;
                        PC_EN   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    read_1EN = 1'b1;
                    read_2EN = 1'b1;
                    if (op_class.halt) begin
                        state_d = S_HALT;
                    end else if (op_class.illegal) begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    if (op_class.alu) begin
                        if (opcode_q == OP_SUB) begin
                            alu_control = ALU_SUB;
                        end else if (opcode_q == OP_RTR) begin
                            alu_control = ALU_PASS_A;
                        end
                        state_d = S_WB;
                    end else if (op_class.jump) begin
                        PC_EN    = 1'b1;
                        PC_in_op = 1'b1;
                    end else if (op_class.branch) begin
                        alu_control = ALU_SUB;
                        PC_EN       = LT_flag;
                        PC_in_op    = LT_flag;
                    end else if (op_class.load || op_class.store) begin
                        EN_mem_add = 1'b1;
                        state_d    = S_MEM;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    RAM_wrEN = op_class.store;
                    if (mem_ack) begin
                        state_d = op_class.store ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    reg_file_wrEN         = 1'b1;
                    write_reg_from_memory = op_class.load;
                    state_d               = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (run) begin
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected control vectors
// are queued as stimulus is applied and compared at the falling edge.
module tb_cpu_sequencer;

    logic       clock;
    logic       reset_n;
    logic       run;
    logic [3:0] opcode;
    logic       LT_flag;
    logic       mem_ack;
    logic [2:0] state;
    logic       PC_EN, PC_in_op, IR_EN;
    logic       read_1EN, read_2EN, reg_file_wrEN, write_reg_from_memory;
    logic [1:0] alu_control;
    logic       EN_mem_add, mem_req, RAM_wrEN, halted, illegal_op;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_en;
        logic       pc_op;
        logic       ir_en;
        logic       rd1;
        logic       rd2;
        logic       wr;
        logic       wr_mem;
        logic [1:0] alu;
        logic       mem_add;
        logic       mreq;
        logic       ram_wr;
        logic       hlt;
        logic       ill;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic [3:0] op;
        logic       lt;
        logic       ack;
        obs_t       exp;
    } stim_t;

    stim_t stim_q[$];
    obs_t  sb[$];
    int    errors = 0;
    int    checks = 0;

    cpu_sequencer dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .run                   (run),
        .opcode                (opcode),
        .LT_flag               (LT_flag),
        .mem_ack               (mem_ack),
        .state                 (state),
        .PC_EN                 (PC_EN),
        .PC_in_op              (PC_in_op),
        .IR_EN                 (IR_EN),
        .read_1EN              (read_1EN),
        .read_2EN              (read_2EN),
        .reg_file_wrEN         (reg_file_wrEN),
        .write_reg_from_memory (write_reg_from_memory),
        .alu_control           (alu_control),
        .EN_mem_add            (EN_mem_add),
        .mem_req               (mem_req),
        .RAM_wrEN              (RAM_wrEN),
        .halted                (halted),
        .illegal_op            (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected vectors per state, written directly from the control table.
    function automatic obs_t o_zero();
        obs_t v = '0;
        return v;
    endfunction
    function automatic obs_t o_fetch(input logic ack);
        obs_t v = '0;
        v.st = 3'd1; v.mreq = 1'b1; v.ir_en = ack; v.pc_en = ack;
        return v;
    endfunction
    function automatic obs_t o_decode(input logic ill);
        obs_t v = '0;
        v.st = 3'd2; v.rd1 = 1'b1; v.rd2 = 1'b1; v.ill = ill;
        return v;
    endfunction
    function automatic obs_t o_exec_alu(input logic [1:0] alu);
        obs_t v = '0;
        v.st = 3'd3; v.alu = alu;
        return v;
    endfunction
    function automatic obs_t o_exec_jmp();
        obs_t v = '0;
        v.st = 3'd3; v.pc_en = 1'b1; v.pc_op = 1'b1;
        return v;
    endfunction
    function automatic obs_t o_exec_blt(input logic lt);
        obs_t v = '0;
        v.st = 3'd3; v.alu = 2'b01; v.pc_en = lt; v.pc_op = lt;
        return v;
    endfunction
    function automatic obs_t o_exec_mem();
        obs_t v = '0;
        v.st = 3'd3; v.mem_add = 1'b1;
        return v;
    endfunction
    function automatic obs_t o_mem(input logic store);
        obs_t v = '0;
        v.st = 3'd4; v.mreq = 1'b1; v.ram_wr = store;
        return v;
    endfunction
    function automatic obs_t o_wb(input logic load);
        obs_t v = '0;
        v.st = 3'd5; v.wr = 1'b1; v.wr_mem = load;
        return v;
    endfunction
    function automatic obs_t o_halt();
        obs_t v = '0;
        v.st = 3'd6; v.hlt = 1'b1;
        return v;
    endfunction

    function automatic obs_t sample();
        return {state, PC_EN, PC_in_op, IR_EN, read_1EN, read_2EN, reg_file_wrEN,
                write_reg_from_memory, alu_control, EN_mem_add, mem_req, RAM_wrEN,
                halted, illegal_op};
    endfunction

    task automatic add(input logic rst, input logic r, input logic [3:0] op,
                       input logic lt, input logic ack, input obs_t exp);
        stim_t s;
        s.rst = rst; s.run = r; s.op = op; s.lt = lt; s.ack = ack; s.exp = exp;
        stim_q.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        reset_n = s.rst; run = s.run; opcode = s.op; LT_flag = s.lt; mem_ack = s.ack;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        obs_t got, want;
        int n = 0;
        add(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, o_zero());
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_zero());
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_zero());
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    // ADD with zero-wait memory, run held high, opcode changed after DECODE.
    task automatic test_add();
        obs_t got, want;
        int n = 0;
        add(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, o_zero());
        add(1'b1, 1'b1, 4'b0110, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b1, 4'b0110, 1'b0, 1'b1, o_decode(1'b0));
        add(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, o_exec_alu(2'b00));
        add(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, o_wb(1'b0));
        add(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, o_fetch(1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL add[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    // SUB, RTR and zero-wait STW, each starting in FETCH.
    task automatic test_alu_store();
        obs_t got, want;
        int n = 0;
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_exec_alu(2'b01));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_wb(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_exec_alu(2'b10));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_wb(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_exec_mem());
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_mem(1'b1));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_fetch(1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL alu_store[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    // LDW with three wait cycles; mem_ack in EXEC must be ignored.
    task automatic test_load_wait();
        obs_t got, want;
        int n = 0;
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, o_exec_mem());
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, o_mem(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_mem(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_wb(1'b1));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_fetch(1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_wait[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    // BLT taken then not taken, then JMP; all return to FETCH.
    task automatic test_branch();
        obs_t got, want;
        int n = 0;
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0101, 1'b0, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, o_exec_blt(1'b1));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_exec_blt(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_exec_jmp());
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_fetch(1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_illegal_halt();
        obs_t got, want;
        int n = 0;
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, o_decode(1'b1));
        add(1'b1, 1'b0, 4'b1010, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_halt());
        add(1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, o_halt());
        add(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, o_halt());
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_fetch(1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL illegal_halt[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    // STW interrupted by reset while mem_ack is pending in MEM.
    task automatic test_reset_mid_mem();
        obs_t got, want;
        int n = 0;
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, o_fetch(1'b1));
        add(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, o_decode(1'b0));
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_exec_mem());
        add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, o_mem(1'b1));
        add(1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, o_zero());
        add(1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, o_zero());
        add(1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, o_zero());
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clock);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_mem[%0d] got=%h want=%h", n, got, want);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; opcode = 4'b0000; LT_flag = 1'b0; mem_ack = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_add();
        test_alu_store();
        test_load_wait();
        test_branch();
        test_illegal_halt();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-003 SHALL have port: run  in  1  start/resume request from IDLE or HALT.
REQ-004 SHALL have port: opcode  in  4  instruction register opcode field, sampled in DECODE.
REQ-005 SHALL have port: LT_flag  in  1  ALU less-than result, sampled in EXEC.
REQ-006 SHALL have port: mem_ack  in  1  memory completion, qualifies mem_req.
REQ-007 SHALL have port: state  out  3  current sequencer state encoding.
REQ-008 SHALL have ports: PC_EN, PC_in_op, IR_EN  out  1 each  PC update, PC load-from-operand select, IR load.
REQ-009 SHALL have ports: read_1EN, read_2EN, reg_file_wrEN, write_reg_from_memory  out  1 each  register file controls.
REQ-010 SHALL have ports: alu_control  out  2  (00 add, 01 sub, 10 pass A); EN_mem_add, mem_req, RAM_wrEN  out  1 each.
REQ-011 SHALL have ports: halted, illegal_op  out  1 each  status.

Function
REQ-012 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 is unreachable and SHALL recover to IDLE.
REQ-013 Opcodes SHALL be 0001 JMP, 0010 LDW, 0011 STW, 0100 RTR, 0101 BLT, 0110 ADD, 0111 SUB, 1111 HLT; all others are illegal.
REQ-014 IDLE: all controls 0; run=1 -> FETCH.
REQ-015 FETCH: mem_req=1 every cycle; on mem_ack=1, IR_EN=1 and PC_EN=1 (PC+1) in that same cycle -> DECODE; otherwise stay, waiting without limit.
REQ-016 DECODE: read_1EN=read_2EN=1; opcode latched into internal opcode_q. HLT -> HALT; illegal -> FETCH with illegal_op=1 for exactly this cycle; all others -> EXEC.
REQ-017 EXEC, ADD/SUB/RTR: alu_control 00/01/10 respectively -> WB.
REQ-018 EXEC, JMP: PC_EN=1, PC_in_op=1 -> FETCH.
REQ-019 EXEC, BLT: alu_control=01; if LT_flag=1 then PC_EN=1, PC_in_op=1; -> FETCH in both cases.
REQ-020 EXEC, LDW/STW: EN_mem_add=1 -> MEM.
REQ-021 MEM: mem_req=1, RAM_wrEN=1 only for STW; on mem_ack, STW -> FETCH and LDW -> WB; otherwise stay.
REQ-022 WB: reg_file_wrEN=1; write_reg_from_memory=1 only for LDW -> FETCH.
REQ-023 HALT: halted=1, no other controls asserted; run=1 -> FETCH.
REQ-024 All outputs SHALL be decoded from state, opcode_q and the listed inputs only; any output not named for a state SHALL be 0.
REQ-025 Latency with zero-wait memory (mem_ack high with mem_req): JMP/BLT 3 cycles, ADD/SUB/RTR 4, STW 4, LDW 5, from FETCH entry to next FETCH entry.
REQ-026 mem_ack outside FETCH/MEM SHALL be ignored; opcode changes outside DECODE SHALL be ignored.
REQ-027 run held continuously high SHALL have no effect outside IDLE/HALT.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force state=IDLE and opcode_q=0000 regardless of current state, including mid-MEM with mem_ack pending.
REQ-029 During and after the reset cycle every output SHALL be 0 (state=000); no RAM_wrEN or reg_file_wrEN pulse SHALL leak across reset.

Structure
REQ-030 State encodings, opcode constants and alu_control codes SHALL live in shared package cpu_pkg for reuse by control_matrix replacements and benches.
REQ-031 Opcode classification (jump, branch, mem-load, mem-store, alu, halt, illegal) SHALL be a combinational sub-module op_classify; the FSM and output decode stay in cpu_sequencer.

Verification
REQ-032 Reset then run=1, opcode=0110, mem_ack tied 1 -> states 1,2,3,5,1; alu_control=00 in EXEC; reg_file_wrEN=1 only in WB.
REQ-033 opcode=0010 with mem_ack delayed 3 cycles in MEM -> mem_req high 4 cycles in MEM, RAM_wrEN=0, then WB with write_reg_from_memory=1.
REQ-034 opcode=0101 with LT_flag=1, then again with LT_flag=0 -> PC_in_op=PC_EN=1 in EXEC only in the first case; both return to FETCH.
REQ-035 opcode=1010 -> illegal_op single-cycle pulse in DECODE, next state FETCH; opcode=1111 -> HALT, halted=1 until run=1.
REQ-036 opcode=0011, reset_n=0 during MEM before mem_ack -> state=000 next cycle, RAM_wrEN=0 from that cycle onward.
